// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/memory-access controller.
// Used by pipeline_ctrl and pipe_timeout_cnt.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 32'd16;

    // Wide enough for the largest supported TIMEOUT (255).
    localparam int unsigned CNT_W = 32'd8;

endpackage

// File: rtl/pipe_timeout_cnt.sv
// Outstanding-access age counter; expire fires in the TIMEOUT-th enabled cycle.
// Only instantiated when PIPE_CTRL_TIMEOUT_EN is defined.
module pipe_timeout_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 32'd1);

    logic [CNT_W-1:0] cnt_r;

    // Expiry is combinational so the controller can abort in the same cycle.
    always_comb begin
        expire = 1'b0;
        if (enable && (cnt_r == LAST_COUNT)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

    // Age counter: cleared when idle or on expiry, otherwise counts enabled cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear || expire) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: data-memory handshake FSM, stall/flush generation and
// memory-stage forwarding. Optional access timeout under macro PIPE_CTRL_TIMEOUT_EN.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned REGW    = 5,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic            reg_write_m,
    input  logic [REGW-1:0] rd_m,
    input  logic [REGW-1:0] rs1_e,
    input  logic [REGW-1:0] rs2_e,
    input  logic            br_taken_e,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic            stall_o,
    output logic            flush_o,
    output logic            fwd_a_o,
    output logic            fwd_b_o,
    output logic            err_o
);

    state_e state_r;
    state_e state_nxt_s;
    logic   store_r;
    logic   store_nxt_s;
    logic   pend_r;
    logic   pend_nxt_s;
    logic   req_s;
    logic   we_s;
    logic   stall_s;
    logic   flush_s;
    logic   fwd_a_s;
    logic   fwd_b_s;
    logic   busy_s;
    logic   expire_s;

    assign busy_s = (state_r != ST_IDLE);

`ifdef PIPE_CTRL_TIMEOUT_EN
    logic clear_s;
    assign clear_s = ~busy_s;

    pipe_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (clear_s),
        .enable (busy_s),
        .expire (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // Handshake FSM: next state and raw request/stall decisions.
    always_comb begin
        state_nxt_s = state_r;
        store_nxt_s = store_r;
        req_s       = 1'b0;
        we_s        = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_write_m || mem_read_m) begin
                    req_s = 1'b1;
                    we_s  = mem_write_m;
                    if (dmem_gnt_i) begin
                        // A granted store completes without stalling the pipe.
                        stall_s     = ~mem_write_m;
                        state_nxt_s = mem_write_m ? ST_IDLE : ST_WAIT_RSP;
                    end else begin
                        stall_s     = 1'b1;
                        state_nxt_s = ST_REQ;
                        store_nxt_s = mem_write_m;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (dmem_gnt_i) begin
                    req_s       = 1'b1;
                    we_s        = store_r;
                    stall_s     = ~store_r;
                    state_nxt_s = store_r ? ST_IDLE : ST_WAIT_RSP;
                end else begin
                    req_s   = 1'b1;
                    we_s    = store_r;
                    stall_s = 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                if (expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (dmem_rvalid_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Branch flushes are deferred while stalled and released on the first free cycle.
    always_comb begin
        flush_s    = (~stall_s) & (br_taken_e | pend_r);
        pend_nxt_s = stall_s & (br_taken_e | pend_r);
    end

    // Forward the memory-stage result when it targets a live source register.
    always_comb begin
        fwd_a_s = 1'b0;
        fwd_b_s = 1'b0;
        if (reg_write_m && (rd_m != {REGW{1'b0}})) begin
            fwd_a_s = (rd_m == rs1_e);
            fwd_b_s = (rd_m == rs2_e);
        end else begin
            fwd_a_s = 1'b0;
            fwd_b_s = 1'b0;
        end
    end

    // Output gating: everything is held low while reset is asserted.
    always_comb begin
        dmem_req_o = 1'b0;
        dmem_we_o  = 1'b0;
        stall_o    = 1'b0;
        flush_o    = 1'b0;
        fwd_a_o    = 1'b0;
        fwd_b_o    = 1'b0;
        err_o      = 1'b0;
        if (rst_i) begin
            dmem_req_o = 1'b0;
        end else begin
            dmem_req_o = req_s;
            dmem_we_o  = we_s;
            stall_o    = stall_s;
            flush_o    = flush_s;
            fwd_a_o    = fwd_a_s;
            fwd_b_o    = fwd_b_s;
            err_o      = expire_s;
        end
    end

    // State, latched access type and pending-flush registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            store_r <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            store_r <= store_nxt_s;
            pend_r  <= pend_nxt_s;
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter DW, default 32, data width.
REQ-002 Parameter REGW, default 5, register-index width.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles a data-memory access may stay outstanding (range 2..255).
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 mem_read_m  in  1  load instruction in memory stage.
REQ-007 mem_write_m  in  1  store instruction in memory stage.
REQ-008 reg_write_m  in  1  memory-stage instruction writes rd_m.
REQ-009 rd_m  in  REGW  memory-stage destination register.
REQ-010 rs1_e, rs2_e  in  REGW each  execute-stage source registers.
REQ-011 br_taken_e  in  1  branch/jump taken in execute stage.
REQ-012 dmem_gnt_i  in  1  data memory accepted the request this cycle.
REQ-013 dmem_rvalid_i  in  1  load data valid this cycle.
REQ-014 dmem_req_o  out  1  data-memory request.
REQ-015 dmem_we_o  out  1  request is a store.
REQ-016 stall_o  out  1  hold all pipeline registers.
REQ-017 flush_o  out  1  clear the fetch/execute pipeline register.
REQ-018 fwd_a_o, fwd_b_o  out  1 each  forward memory-stage result to ALU operand A/B.
REQ-019 err_o  out  1  one-cycle access-timeout pulse.

Function
REQ-020 The FSM SHALL have states IDLE, REQ and WAIT_RSP.
REQ-021 In IDLE with mem_write_m or mem_read_m high, dmem_req_o SHALL be 1 in the same cycle (combinational); dmem_we_o SHALL equal mem_write_m.
REQ-022 If both mem_read_m and mem_write_m are high, the access SHALL be treated as a store.
REQ-023 Store with dmem_gnt_i=1: stall_o=0 that cycle; FSM stays in IDLE.
REQ-024 Load with dmem_gnt_i=1: stall_o=1 that cycle; next state WAIT_RSP.
REQ-025 Any access with dmem_gnt_i=0: stall_o=1; next state REQ.
REQ-026 In REQ: dmem_req_o=1, dmem_we_o held, stall_o=1 until grant.
REQ-027 On grant in REQ: a store returns to IDLE with stall_o=0 in the grant cycle; a load moves to WAIT_RSP.
REQ-028 In WAIT_RSP: dmem_req_o=0; stall_o=1 until the dmem_rvalid_i cycle, when stall_o=0 and the next state is IDLE.
REQ-029 dmem_rvalid_i outside WAIT_RSP SHALL be ignored.
REQ-030 flush_o SHALL equal br_taken_e when stall_o=0.
REQ-031 When br_taken_e=1 while stall_o=1, a pending-flush flag SHALL be set, and flush_o SHALL assert in the first cycle with stall_o=0; the flag then clears.
REQ-032 fwd_a_o SHALL be 1 iff reg_write_m=1, rd_m!=0 and rd_m==rs1_e; fwd_b_o follows the same rule using rs2_e. Both are combinational.

Reset
REQ-033 While rst_i=1, all outputs SHALL be 0; on the next edge the state SHALL be IDLE, the timeout counter 0 and the pending-flush flag 0.
REQ-034 Reset asserted mid-access SHALL abandon the access; no request is re-issued after reset unless a memory op is still present in IDLE.

Configuration
REQ-035 With macro PIPE_CTRL_TIMEOUT_EN defined, a counter SHALL count cycles spent in REQ or WAIT_RSP.
REQ-036 With PIPE_CTRL_TIMEOUT_EN defined and the counter reaching TIMEOUT-1: err_o=1 for one cycle, stall_o=0, dmem_req_o=0, next state IDLE, counter cleared.
REQ-037 Without PIPE_CTRL_TIMEOUT_EN, no counter SHALL exist, err_o SHALL be tied to 0, and accesses wait indefinitely.

Structure
REQ-038 Package pipe_ctrl_pkg SHALL hold the state enum type and the default TIMEOUT constant.
REQ-039 The timeout counter SHALL be the sub-module pipe_timeout_cnt (clear, enable, expire), instantiated only under PIPE_CTRL_TIMEOUT_EN.

Verification
REQ-040 Store, dmem_gnt_i=1 immediately -> dmem_req_o=1, dmem_we_o=1, stall_o=0, FSM stays in IDLE.
REQ-041 Load, grant after 3 cycles, rvalid 2 cycles later -> stall_o high for 5 cycles, low in the rvalid cycle.
REQ-042 br_taken_e=1 during a load stall -> flush_o=0 during the stall, flush_o=1 in the first unstalled cycle only.
REQ-043 rd_m=5, reg_write_m=1, rs1_e=5, rs2_e=5 -> fwd_a_o=fwd_b_o=1; with rd_m=0 -> both 0.
REQ-044 PIPE_CTRL_TIMEOUT_EN, TIMEOUT=16, load never granted -> err_o pulses exactly once, at cycle 16, then the FSM is in IDLE.
REQ-045 rst_i asserted in WAIT_RSP -> all outputs 0, FSM in IDLE, and a later dmem_rvalid_i has no effect.
